// File: rtl/ltmr_seu_monitor.sv
// ---------------------------------------------------------------------------
// ltmr_seu_monitor
//
// Purpose
//   Sits behind the triplicated register banks. Majority-votes the three
//   WIDTH-bit copies, detects copies that disagree bit by bit (single event
//   upsets), remembers which copy was the odd one out, reports each upset
//   once over a valid/ready event port and keeps a saturating count of
//   accepted events. Optionally requests a scrub (CORR) so the banks reload
//   the voted value.
//
// Configuration
//   LTMR_SEU_AUTOCORRECT_EN  defined   : CAPTURE state present, CORR pulses
//                                        for one cycle before each report
//                                        burst (event valid at k+3).
//                            undefined : CORR tied low, IDLE goes straight
//                                        to REPORT (event valid at k+2).
//
// Ports
//   CP         in   1      clock, all state updates on the rising edge
//   RST        in   1      synchronous active-high reset
//   A, B, C    in   WIDTH  the three register copies
//   Q          out  WIDTH  combinational bitwise majority of A/B/C
//   CORR       out  1      one-cycle scrub request
//   EVT_VALID  out  1      upset event available
//   EVT_READY  in   1      consumer accepts the event
//   EVT_IDX    out  IDX_W  bit index of the reported upset (0 when idle)
//   EVT_COPY   out  2      upset copy 1=A 2=B 3=C (0 when idle)
//   CNT_CLR    in   1      synchronous counter clear (beats a coincident ack)
//   SEU_CNT    out  CNT_W  saturating count of accepted events
// ---------------------------------------------------------------------------
module ltmr_seu_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Q,
  output logic             CORR,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [IDX_W-1:0] EVT_IDX,
  output logic [1:0]       EVT_COPY,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] SEU_CNT
);

`ifdef LTMR_SEU_AUTOCORRECT_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REPORT  = 2'd2
  } state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state
  state_t                 state_q,     state_d;
  logic [WIDTH-1:0]       mis_q,       mis_d;
  logic [WIDTH-1:0]       mis_dly_q,   mis_dly_d;
  logic [WIDTH-1:0][1:0]  copy_id_q,   copy_id_d;
  logic [WIDTH-1:0][1:0]  copy_pend_q, copy_pend_d;
  logic [WIDTH-1:0]       pending_q,   pending_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;

  // Combinational helpers
  logic [WIDTH-1:0]       new_upset;
  logic [WIDTH-1:0]       ack_mask;
  logic [IDX_W-1:0]       low_idx;
  logic                   evt_valid;
  logic                   ack;

  // The vote is purely combinational so the banks see corrected data with
  // zero latency, independent of reset.
  assign Q = (A & B) | (B & C) | (C & A);

  // Mismatch detection and per-bit identification of the odd copy. With
  // three binary copies at least two always agree, so the priority chain
  // below always names the single disagreeing copy when there is one.
  always_comb begin
    mis_d     = (A ^ B) | (B ^ C);
    mis_dly_d = mis_q;
    copy_id_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (B[i] == C[i]) begin
        copy_id_d[i] = 2'd1;
      end else if (A[i] == C[i]) begin
        copy_id_d[i] = 2'd2;
      end else begin
        copy_id_d[i] = 2'd3;
      end
    end
  end

  // Only the rising edge of a mismatch is a new upset; a stuck mismatch is
  // reported once and only re-reported after it clears and reappears.
  assign new_upset = mis_q & ~mis_dly_q;

  // Lowest pending bit is the one presented on the event port. Scanning from
  // the top down lets the last hit (the lowest index) win.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign evt_valid = (state_q == ST_REPORT);
  assign ack       = evt_valid & EVT_READY;
  assign ack_mask  = ack ? (WIDTH'(1) << low_idx) : '0;

  // Pending set and the stored copy IDs. A new upset on the same bit as the
  // ack wins: the bit stays pending and its copy ID is refreshed.
  always_comb begin
    pending_d   = (pending_q & ~ack_mask) | new_upset;
    copy_pend_d = copy_pend_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (new_upset[i]) begin
        copy_pend_d[i] = copy_id_q[i];
      end
    end
  end

  // Saturating event counter; a clear beats a coincident ack.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (ack && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Report sequencer. New upsets arriving while reporting merge into the
  // pending set and are drained back-to-back without another scrub pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
`ifdef LTMR_SEU_AUTOCORRECT_EN
          state_d = ST_CAPTURE;
`else
          state_d = ST_REPORT;
`endif
        end
      end
`ifdef LTMR_SEU_AUTOCORRECT_EN
      ST_CAPTURE: begin
        state_d = ST_REPORT;
      end
`endif
      ST_REPORT: begin
        if (pending_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Event port outputs are forced to zero while nothing is offered.
  always_comb begin
    EVT_VALID = evt_valid;
    EVT_IDX   = evt_valid ? low_idx : '0;
    EVT_COPY  = evt_valid ? copy_pend_q[low_idx] : 2'd0;
    SEU_CNT   = cnt_q;
`ifdef LTMR_SEU_AUTOCORRECT_EN
    CORR      = (state_q == ST_CAPTURE);
`else
    CORR      = 1'b0;
`endif
  end

  // All state is synchronously reset; a reset mid-report discards every
  // pending event.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mis_q       <= '0;
      mis_dly_q   <= '0;
      copy_id_q   <= '0;
      copy_pend_q <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mis_q       <= mis_d;
      mis_dly_q   <= mis_dly_d;
      copy_id_q   <= copy_id_d;
      copy_pend_q <= copy_pend_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ltmr_seu_monitor.sv
// ---------------------------------------------------------------------------
// tb_ltmr_seu_monitor
//
// Self-checking bench for ltmr_seu_monitor with WIDTH=8, CNT_W=4. Expected
// events are queued when upsets are injected and compared by a negedge
// monitor as the DUT offers them. Builds with or without
// LTMR_SEU_AUTOCORRECT_EN; latency and scrub expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_ltmr_seu_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;
  localparam int CNT_SAT = 15;
`ifdef LTMR_SEU_AUTOCORRECT_EN
  localparam int LAT = 3;
  localparam int CORR_PULSES = 1;
`else
  localparam int LAT = 2;
  localparam int CORR_PULSES = 0;
`endif

  logic             CP;
  logic             RST;
  logic [WIDTH-1:0] A, B, C;
  logic [WIDTH-1:0] Q;
  logic             CORR;
  logic             EVT_VALID;
  logic             EVT_READY;
  logic [IDX_W-1:0] EVT_IDX;
  logic [1:0]       EVT_COPY;
  logic             CNT_CLR;
  logic [CNT_W-1:0] SEU_CNT;

  typedef struct {
    int idx;
    int copy;
  } evt_t;

  evt_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cntModel = 0;
  int   evtSeen = 0;
  int   corrSeen = 0;

  ltmr_seu_monitor #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) dut (
    .CP(CP),
    .RST(RST),
    .A(A),
    .B(B),
    .C(C),
    .Q(Q),
    .CORR(CORR),
    .EVT_VALID(EVT_VALID),
    .EVT_READY(EVT_READY),
    .EVT_IDX(EVT_IDX),
    .EVT_COPY(EVT_COPY),
    .CNT_CLR(CNT_CLR),
    .SEU_CNT(SEU_CNT)
  );

  // Free-running clock
  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Vote model counted bit by bit rather than from the and/or formula
  function automatic logic [WIDTH-1:0] voteModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    A = a;
    B = b;
    C = c;
  endtask

  task automatic stepCycle();
    @(posedge CP);
    #1;
  endtask

  task automatic resetDut();
    RST = 1'b1;
    stepCycle();
    stepCycle();
    RST = 1'b0;
  endtask

  task automatic pushEvt(input int idx, input int copy);
    evt_t e;
    e.idx = idx;
    e.copy = copy;
    expQ.push_back(e);
  endtask

  task automatic waitValid(input int maxCycles);
    int n;
    n = 0;
    while (!EVT_VALID && n < maxCycles) begin
      stepCycle();
      n++;
    end
    if (!EVT_VALID) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge CP) begin
    checkOutput("q_vote", Q, voteModel(A, B, C));
    if (RST) begin
      expQ.delete();
      cntModel = 0;
    end else begin
      checkOutput("seu_cnt", SEU_CNT, cntModel);
      if (CORR === 1'b1) corrSeen++;
`ifndef LTMR_SEU_AUTOCORRECT_EN
      checkOutput("corr_tied_low", CORR, 32'd0);
`endif
      if (EVT_VALID !== 1'b1) begin
        checkOutput("idx_zero_idle", EVT_IDX, 32'd0);
        checkOutput("copy_zero_idle", EVT_COPY, 32'd0);
      end else begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", 32'd1, 32'd0);
        end else begin
          checkOutput("evt_idx", EVT_IDX, expQ[0].idx);
          checkOutput("evt_copy", EVT_COPY, expQ[0].copy);
        end
      end
      if (CNT_CLR) begin
        cntModel = 0;
      end else if (EVT_VALID && EVT_READY && cntModel < CNT_SAT) begin
        cntModel++;
      end
      if (EVT_VALID && EVT_READY) begin
        evtSeen++;
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int firstValid;
    int firstCorr;
    int validCycles;
    int evtBase;
    int corrBase;
    logic [WIDTH-1:0] m;

    RST = 1'b1;
    EVT_READY = 1'b0;
    CNT_CLR = 1'b0;
    applyStimulus(8'hA5, 8'hA5, 8'hA5);

    // 1: reset and quiet operation
    resetDut();
    for (int j = 0; j < 4; j++) begin
      stepCycle();
      checkOutput("t1_q", Q, 32'hA5);
      checkOutput("t1_valid", EVT_VALID, 32'd0);
      checkOutput("t1_corr", CORR, 32'd0);
      checkOutput("t1_cnt", SEU_CNT, 32'd0);
    end

    // 2: single bit0 upset on copy B, consumer always ready
    $display("[TB] single upset on B bit0");
    resetDut();
    EVT_READY = 1'b1;
    applyStimulus(8'hA5, 8'hA4, 8'hA5);
    pushEvt(0, 2);
    firstValid = -1;
    firstCorr = -1;
    validCycles = 0;
    for (int j = 0; j < 8; j++) begin
      stepCycle();
      checkOutput("t2_q", Q, 32'hA5);
      if (EVT_VALID) begin
        validCycles++;
        if (firstValid < 0) firstValid = j;
      end
      if (CORR && firstCorr < 0) firstCorr = j;
    end
    checkOutput("t2_valid_latency", firstValid, LAT);
`ifdef LTMR_SEU_AUTOCORRECT_EN
    checkOutput("t2_corr_latency", firstCorr, 32'd2);
`else
    checkOutput("t2_corr_never", firstCorr, 32'hFFFFFFFF);
`endif
    checkOutput("t2_valid_cycles", validCycles, 32'd1);
    checkOutput("t2_cnt", SEU_CNT, 32'd1);
    applyStimulus(8'hA5, 8'hA5, 8'hA5);
    for (int j = 0; j < 3; j++) stepCycle();

    // 3: two simultaneous upsets, consumer stalls
    $display("[TB] two upsets with backpressure");
    resetDut();
    EVT_READY = 1'b0;
    applyStimulus(8'hA5 ^ 8'h08, 8'hA5, 8'hA5 ^ 8'h40);
    pushEvt(3, 1);
    pushEvt(6, 3);
    waitValid(10);
    for (int j = 0; j < 5; j++) begin
      checkOutput("t3_hold_idx", EVT_IDX, 32'd3);
      checkOutput("t3_hold_copy", EVT_COPY, 32'd1);
      stepCycle();
    end
    EVT_READY = 1'b1;
    stepCycle();
    checkOutput("t3_second_valid", EVT_VALID, 32'd1);
    checkOutput("t3_second_idx", EVT_IDX, 32'd6);
    checkOutput("t3_second_copy", EVT_COPY, 32'd3);
    stepCycle();
    checkOutput("t3_idle", EVT_VALID, 32'd0);
    checkOutput("t3_cnt", SEU_CNT, 32'd2);
    applyStimulus(8'hA5, 8'hA5, 8'hA5);
    for (int j = 0; j < 3; j++) stepCycle();

    // 4: stuck upset on B bit7 reports exactly once
    $display("[TB] stuck upset on B bit7");
    resetDut();
    EVT_READY = 1'b1;
    evtBase = evtSeen;
    corrBase = corrSeen;
    applyStimulus(8'hA5, 8'hA5 ^ 8'h80, 8'hA5);
    pushEvt(7, 2);
    firstValid = -1;
    for (int j = 0; j < 20; j++) begin
      stepCycle();
      if (EVT_VALID && firstValid < 0) firstValid = j;
    end
    checkOutput("t4_latency", firstValid, LAT);
    checkOutput("t4_event_count", evtSeen - evtBase, 32'd1);
    checkOutput("t4_corr_count", corrSeen - corrBase, CORR_PULSES);
    applyStimulus(8'hA5, 8'hA5, 8'hA5);
    for (int j = 0; j < 3; j++) stepCycle();

    // 5: counter saturation and clear beating an ack
    $display("[TB] counter saturation");
    resetDut();
    EVT_READY = 1'b1;
    for (int n = 0; n < 17; n++) begin
      m = 8'(1 << (n % 8));
      applyStimulus(8'hA5 ^ m, 8'hA5, 8'hA5);
      pushEvt(n % 8, 1);
      for (int j = 0; j < 4; j++) stepCycle();
      applyStimulus(8'hA5, 8'hA5, 8'hA5);
      for (int j = 0; j < 4; j++) stepCycle();
    end
    checkOutput("t5_saturated", SEU_CNT, CNT_SAT);
    applyStimulus(8'hA5, 8'hA5 ^ 8'h04, 8'hA5);
    pushEvt(2, 2);
    waitValid(10);
    CNT_CLR = 1'b1;
    stepCycle();
    CNT_CLR = 1'b0;
    checkOutput("t5_clear_wins", SEU_CNT, 32'd0);
    applyStimulus(8'hA5, 8'hA5, 8'hA5);
    for (int j = 0; j < 3; j++) stepCycle();

    // 6: reset while reporting with three bits pending
    $display("[TB] reset mid-report");
    resetDut();
    EVT_READY = 1'b0;
    applyStimulus(8'hA5 ^ 8'h16, 8'hA5, 8'hA5);
    pushEvt(1, 1);
    pushEvt(2, 1);
    pushEvt(4, 1);
    waitValid(10);
    stepCycle();
    checkOutput("t6_valid_before", EVT_VALID, 32'd1);
    RST = 1'b1;
    applyStimulus(8'hA5, 8'hA5, 8'hA5);
    stepCycle();
    checkOutput("t6_valid_reset", EVT_VALID, 32'd0);
    checkOutput("t6_corr_reset", CORR, 32'd0);
    checkOutput("t6_idx_reset", EVT_IDX, 32'd0);
    checkOutput("t6_copy_reset", EVT_COPY, 32'd0);
    checkOutput("t6_cnt_reset", SEU_CNT, 32'd0);
    RST = 1'b0;
    EVT_READY = 1'b1;
    evtBase = evtSeen;
    for (int j = 0; j < 10; j++) stepCycle();
    checkOutput("t6_no_more_events", evtSeen - evtBase, 32'd0);
    checkOutput("t6_valid_after", EVT_VALID, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
